tri_dispatch_arbiter: RTL and testbench
=======================================

// Module: tri_dispatch_arbiter
// PURPOSE
// Shares the single rasterizer between NUM_REQ triangle sources (vertex/setup pipes) using round-robin.
// Latches one triangle and holds it with tri_valid until the rasterizer reports done.
// Owns front/back frame-buffer selection: drives the base address and performs swaps only between triangles.
// PARAMETERS
// NUM_REQ        4          number of requesters, 2..8
// TRI_W          360        packed triangle width: {x1,y1,z1,x2,y2,z2,x3,y3,z3 (9x32), color1..3 (3x24)}
// FB_BASE0       26'h0      frame buffer 0 base address
// FB_BASE1       26'h4B000  frame buffer 1 base address (640*480 words above FB_BASE0)
// TIMEOUT_CYCLES 32'd400000 watchdog limit for one triangle (used only with TRI_DISPATCH_TIMEOUT_EN)
// PORTS
// clock        in   1              clock
// reset        in   1              reset, asynchronous, active-low
// req_valid    in   NUM_REQ        requester i has a triangle; held until its req_ready
// req_tri      in   NUM_REQ*TRI_W  triangle of requester i at [i*TRI_W +: TRI_W]
// req_ready    out  NUM_REQ        one-cycle accept pulse, at most one bit set
// tri_out      out  TRI_W          latched triangle to rasterizer vertex/colour inputs
// tri_valid    out  1              rasterizer in_data_valid
// fb_base      out  26             rasterizer addr_in = frame_sel ? FB_BASE1 : FB_BASE0
// rast_done    in   1              rasterizer done_out; triangle finished
// swap_req     in   1              pulse: request front/back swap
// swap_ack     out  1              one-cycle pulse when swap performed
// frame_sel    out  1              current draw buffer
// busy         out  1              state != IDLE
// tri_count    out  16             triangles completed since last swap, saturating at 16'hFFFF
// err_timeout  out  1              sticky watchdog error, cleared only by reset
// BEHAVIOUR
// Reset (async, reset==0): state=IDLE; all outputs 0; tri_out=0; swap_pend=0; rr_last=NUM_REQ-1, so req 0 has first priority.
// FSM states: IDLE, CAPTURE, RUN, SWAP. All outputs are registered.
// IDLE:
//   if swap_pend: go SWAP; swap has priority over pending requests.
//   else if any req_valid: winner = first set bit scanning rr_last+1 .. rr_last+NUM_REQ (mod NUM_REQ); go CAPTURE.
// CAPTURE, 1 cycle:
//   req_ready[winner]=1; tri_out <= req_tri[winner]; rr_last <= winner; go RUN.
// RUN:
//   tri_valid=1; tri_out and fb_base held stable.
//   On rast_done==1: tri_valid=0 next cycle; tri_count++ (saturating); go IDLE.
//   Latency from req_valid in IDLE: req_ready at +1 cycle, tri_valid at +2.
//   Minimum gap between triangles is 2 cycles (IDLE, CAPTURE).
// SWAP, 1 cycle:
//   frame_sel toggles; swap_ack=1; tri_count=0; swap_pend=0; go IDLE.
// Swap rules:
//   swap_req in any state sets swap_pend; repeated swap_req while pending merge into one swap.
//   swap_req in the same cycle as the SWAP state re-arms swap_pend.
//   An in-flight triangle always completes before a swap.
// rast_done outside RUN is ignored. A deasserted req_valid before grant withdraws the request; no error.
// Simultaneous rast_done and new req_valid: done handled first; arbitration happens in the following IDLE cycle.
// Reset mid-RUN: tri_valid drops asynchronously and the triangle is lost; the rasterizer is reset by the same net.
// CONFIGURATION
// TRI_DISPATCH_TIMEOUT_EN defined:
//   32-bit counter clears on RUN entry and increments each RUN cycle.
//   At TIMEOUT_CYCLES without rast_done: err_timeout<=1 (sticky); tri_valid<=0; go IDLE.
//   tri_count is not incremented for the aborted triangle.
// TRI_DISPATCH_TIMEOUT_EN undefined: no counter; err_timeout tied 0; RUN waits indefinitely.
// TESTING
// 1 Single req: req_valid=4'b0001 -> req_ready=4'b0001 at +1, tri_valid=1 at +2; rast_done pulse -> tri_valid=0, tri_count=1.
// 2 Round-robin: req_valid=4'b1111 held, 8 triangles each with 10-cycle done -> grant order 0,1,2,3,0,1,2,3.
// 3 Swap during RUN: swap_req at cycle 3 of RUN -> no ack until done; then SWAP: swap_ack=1, frame_sel=1, fb_base=26'h4B000, tri_count=0.
// 4 Merged swaps: three swap_req pulses in one RUN -> exactly one swap_ack, frame_sel toggles once.
// 5 Reset mid-RUN: reset=0 at RUN cycle 5 -> tri_valid/busy/req_ready 0 immediately; after release req 0 is granted first.
// 6 Timeout (TRI_DISPATCH_TIMEOUT_EN, TIMEOUT_CYCLES=20): no rast_done -> err_timeout=1 after 20 RUN cycles, tri_valid=0, tri_count unchanged.

Source files
------------

// File: rtl/tri_dispatch_arbiter.sv
// Round-robin dispatcher sharing one rasterizer between NUM_REQ triangle sources, owning the
// front/back frame-buffer swap. Optional watchdog enabled by defining TRI_DISPATCH_TIMEOUT_EN.
module tri_dispatch_arbiter #(
  parameter int          NUM_REQ        = 4,
  parameter int          TRI_W          = 360,
  parameter logic [25:0] FB_BASE0       = 26'h0,
  parameter logic [25:0] FB_BASE1       = 26'h4B000,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd400000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*TRI_W-1:0] req_tri,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [TRI_W-1:0]         tri_out,
  output logic                     tri_valid,
  output logic [25:0]              fb_base,
  input  logic                     rast_done,
  input  logic                     swap_req,
  output logic                     swap_ack,
  output logic                     frame_sel,
  output logic                     busy,
  output logic [15:0]              tri_count,
  output logic                     err_timeout
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, CAPTURE, RUN, SWAP} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   rr_last, winner, grant;
  logic [NUM_REQ-1:0] winner_onehot;
  logic               any_req, swap_pend, timeout_hit;

  // Scan from rr_last+NUM_REQ down to rr_last+1 so the nearest requester after rr_last wins.
  always_comb begin
    int idx;
    idx           = 0;
    winner        = rr_last;
    any_req       = 1'b0;
    winner_onehot = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(rr_last) + k) % NUM_REQ;
      if (req_valid[idx]) begin
        winner  = IDX_W'(idx);
        any_req = 1'b1;
      end
    end
    winner_onehot[winner] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (swap_pend)    state_nxt = SWAP;
        else if (any_req) state_nxt = CAPTURE;
      end
      CAPTURE: state_nxt = RUN;
      RUN:     if (rast_done || timeout_hit) state_nxt = IDLE;
      SWAP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Outputs are set on the edge entering the state in which they must be visible.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      req_ready <= '0;
      tri_out   <= '0;
      tri_valid <= 1'b0;
      fb_base   <= FB_BASE0;
      swap_ack  <= 1'b0;
      frame_sel <= 1'b0;
      busy      <= 1'b0;
      tri_count <= '0;
      swap_pend <= 1'b0;
      grant     <= '0;
      rr_last   <= IDX_W'(NUM_REQ - 1);
    end else begin
      req_ready <= '0;
      swap_ack  <= 1'b0;
      busy      <= (state_nxt != IDLE);
      swap_pend <= (state == SWAP) ? swap_req : (swap_pend | swap_req);
      case (state)
        IDLE: begin
          if (swap_pend) begin
            frame_sel <= ~frame_sel;
            fb_base   <= frame_sel ? FB_BASE0 : FB_BASE1;
            swap_ack  <= 1'b1;
            tri_count <= '0;
          end else if (any_req) begin
            grant     <= winner;
            req_ready <= winner_onehot;
          end
        end
        CAPTURE: begin
          tri_out   <= req_tri[int'(grant)*TRI_W +: TRI_W];
          rr_last   <= grant;
          tri_valid <= 1'b1;
        end
        RUN: begin
          if (rast_done) begin
            tri_valid <= 1'b0;
            if (tri_count != 16'hFFFF) tri_count <= tri_count + 16'd1;
          end else if (timeout_hit) begin
            tri_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef TRI_DISPATCH_TIMEOUT_EN
  logic [31:0] run_cnt;

  // run_cnt counts completed RUN cycles; the abort fires at the end of cycle TIMEOUT_CYCLES.
  assign timeout_hit = (state == RUN) && !rast_done && (run_cnt == TIMEOUT_CYCLES - 32'd1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      run_cnt     <= '0;
      err_timeout <= 1'b0;
    end else if (state == CAPTURE) begin
      run_cnt <= '0;
    end else if (state == RUN) begin
      run_cnt <= run_cnt + 32'd1;
      if (timeout_hit) err_timeout <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_tri_dispatch_arbiter.sv
// Self-checking bench for tri_dispatch_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model.
module tb_tri_dispatch_arbiter;
  localparam int N  = 4;
  localparam int TW = 360;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*TW-1:0] req_tri = '0;
  logic [N-1:0]    req_ready;
  logic [TW-1:0]   tri_out;
  logic            tri_valid;
  logic [25:0]     fb_base;
  logic            rast_done = 1'b0;
  logic            swap_req = 1'b0;
  logic            swap_ack, frame_sel, busy, err_timeout;
  logic [15:0]     tri_count;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  tri_dispatch_arbiter #(.NUM_REQ(N), .TRI_W(TW), .TIMEOUT_CYCLES(32'd20)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_tri(req_tri),
    .req_ready(req_ready), .tri_out(tri_out), .tri_valid(tri_valid), .fb_base(fb_base),
    .rast_done(rast_done), .swap_req(swap_req), .swap_ack(swap_ack), .frame_sel(frame_sel),
    .busy(busy), .tri_count(tri_count), .err_timeout(err_timeout)
  );

  function automatic logic [TW-1:0] rand_tri();
    logic [TW-1:0] t = '0;
    for (int w = 0; w < 12; w++) t = (t << 32) | TW'($urandom());
    return t;
  endfunction

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic apply_reset();
    req_valid = '0; rast_done = 1'b0; swap_req = 1'b0; reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    tests++;
    if ({req_ready, tri_valid, fb_base, swap_ack, frame_sel, busy, tri_count, err_timeout} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: ready=%b valid=%b fb=%h ack=%b sel=%b busy=%b cnt=%0d err=%b, want all 0",
               req_ready, tri_valid, fb_base, swap_ack, frame_sel, busy, tri_count, err_timeout);
    end
    tests++;
    if (tri_out !== '0) begin fails++; $display("FAIL reset_tri_out: got %h want 0", tri_out); end
    reset = 1'b1;
  endtask

  task automatic test_single();
    logic [TW-1:0] t;
    t = rand_tri();
    req_tri[0 +: TW] = t; req_valid = 4'b0001;
    tick();
    tests++;
    if (req_ready !== 4'b0001 || tri_valid !== 1'b0) begin
      fails++; $display("FAIL single_ready: ready=%b valid=%b want 0001/0", req_ready, tri_valid);
    end
    tick();
    req_valid = '0;
    tests++;
    if (tri_valid !== 1'b1 || req_ready !== 4'b0000 || tri_out !== t) begin
      fails++; $display("FAIL single_valid: valid=%b ready=%b tri=%h want 1/0000/%h", tri_valid, req_ready, tri_out, t);
    end
    tick(); tick();
    tests++;
    if (tri_valid !== 1'b1 || busy !== 1'b1) begin
      fails++; $display("FAIL single_hold: valid=%b busy=%b want 1/1", tri_valid, busy);
    end
    rast_done = 1'b1; tick(); rast_done = 1'b0;
    tests++;
    if (tri_valid !== 1'b0 || tri_count !== 16'd1) begin
      fails++; $display("FAIL single_done: valid=%b cnt=%0d want 0/1", tri_valid, tri_count);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int i = 0; i < N; i++) req_tri[i*TW +: TW] = rand_tri();
    req_valid = 4'hF;
    for (int g = 0; g < 8; g++) begin
      int c = 0;
      while (req_ready == '0 && c < 20) begin tick(); c++; end
      tests++;
      if (req_ready !== (4'b0001 << (g % 4))) begin
        fails++; $display("FAIL rr_grant_%0d: ready=%b want %b", g, req_ready, 4'b0001 << (g % 4));
      end
      tick();
      tests++;
      if (tri_valid !== 1'b1 || tri_out !== req_tri[(g % 4)*TW +: TW]) begin
        fails++; $display("FAIL rr_data_%0d: valid=%b tri=%h want %h", g, tri_valid, tri_out, req_tri[(g % 4)*TW +: TW]);
      end
      repeat (9) tick();
      rast_done = 1'b1; tick(); rast_done = 1'b0;
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_swap_during_run();
    bit bad = 0;
    apply_reset();
    req_tri[0 +: TW] = rand_tri(); req_valid = 4'b0001;
    tick(); tick();
    req_valid = '0;
    tick();
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    repeat (8) begin
      tick();
      if (swap_ack !== 1'b0 || frame_sel !== 1'b0 || tri_valid !== 1'b1) bad = 1;
    end
    tests++;
    if (bad) begin fails++; $display("FAIL swap_run_hold: ack=%b sel=%b valid=%b want 0/0/1", swap_ack, frame_sel, tri_valid); end
    rast_done = 1'b1; tick(); rast_done = 1'b0;
    tests++;
    if (tri_valid !== 1'b0 || tri_count !== 16'd1 || swap_ack !== 1'b0) begin
      fails++; $display("FAIL swap_done: valid=%b cnt=%0d ack=%b want 0/1/0", tri_valid, tri_count, swap_ack);
    end
    tick();
    tests++;
    if (swap_ack !== 1'b1 || frame_sel !== 1'b1 || fb_base !== 26'h4B000 || tri_count !== 16'd0) begin
      fails++; $display("FAIL swap_state: ack=%b sel=%b fb=%h cnt=%0d want 1/1/4b000/0", swap_ack, frame_sel, fb_base, tri_count);
    end
    tick();
    tests++;
    if (swap_ack !== 1'b0 || busy !== 1'b0 || frame_sel !== 1'b1) begin
      fails++; $display("FAIL swap_after: ack=%b busy=%b sel=%b want 0/0/1", swap_ack, busy, frame_sel);
    end
  endtask

  task automatic test_merged_swaps();
    int acks = 0;
    req_tri[TW +: TW] = rand_tri(); req_valid = 4'b0010;
    tick(); tick();
    req_valid = '0;
    repeat (3) begin swap_req = 1'b1; tick(); swap_req = 1'b0; tick(); tick(); end
    rast_done = 1'b1; tick(); rast_done = 1'b0;
    repeat (10) begin tick(); acks += int'(swap_ack); end
    tests++;
    if (acks != 1 || frame_sel !== 1'b0 || fb_base !== 26'h0) begin
      fails++; $display("FAIL merged_swaps: acks=%0d sel=%b fb=%h want 1/0/0", acks, frame_sel, fb_base);
    end
  endtask

  task automatic test_reset_mid_run();
    req_tri[2*TW +: TW] = rand_tri(); req_valid = 4'b0100;
    tick(); tick();
    req_valid = '0;
    repeat (4) tick();
    #2 reset = 1'b0;
    #1;
    tests++;
    if (tri_valid !== 1'b0 || busy !== 1'b0 || req_ready !== '0) begin
      fails++; $display("FAIL reset_mid_run: valid=%b busy=%b ready=%b want 0/0/0", tri_valid, busy, req_ready);
    end
    tick();
    reset = 1'b1;
    for (int i = 0; i < N; i++) req_tri[i*TW +: TW] = rand_tri();
    req_valid = 4'hF;
    tick();
    tests++;
    if (req_ready !== 4'b0001) begin fails++; $display("FAIL reset_first_grant: ready=%b want 0001", req_ready); end
    tick();
    req_valid = '0;
    rast_done = 1'b1; tick(); rast_done = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int n = 0;
    logic [15:0] cnt0;
    cnt0 = tri_count;
    req_tri[0 +: TW] = rand_tri(); req_valid = 4'b0001;
    tick(); tick();
    req_valid = '0;
`ifdef TRI_DISPATCH_TIMEOUT_EN
    while (tri_valid === 1'b1 && n < 40) begin n++; tick(); end
    tests++;
    if (n != 20 || err_timeout !== 1'b1 || tri_count !== cnt0 || busy !== 1'b0) begin
      fails++; $display("FAIL timeout_abort: run=%0d err=%b cnt=%0d busy=%b want 20/1/%0d/0", n, err_timeout, tri_count, busy, cnt0);
    end
    req_valid = 4'b0001; tick(); tick(); req_valid = '0;
    rast_done = 1'b1; tick(); rast_done = 1'b0;
    tests++;
    if (err_timeout !== 1'b1 || tri_count !== cnt0 + 16'd1) begin
      fails++; $display("FAIL timeout_sticky: err=%b cnt=%0d want 1/%0d", err_timeout, tri_count, cnt0 + 16'd1);
    end
`else
    while (tri_valid === 1'b1 && err_timeout === 1'b0 && n < 30) begin n++; tick(); end
    tests++;
    if (n != 30 || err_timeout !== 1'b0) begin
      fails++; $display("FAIL no_timeout: run=%0d err=%b want 30/0", n, err_timeout);
    end
    rast_done = 1'b1; tick(); rast_done = 1'b0;
    tests++;
    if (tri_count !== cnt0 + 16'd1 || tri_valid !== 1'b0) begin
      fails++; $display("FAIL no_timeout_done: cnt=%0d valid=%b want %0d/0", tri_count, tri_valid, cnt0 + 16'd1);
    end
`endif
    tick();
  endtask

  // Reference model: phase 0 free, 1 grant issued, 2 rasterizing, 3 swapping.
  task automatic test_random();
    int            ph = 0;
    bit            pend = 0, sel = 0, vld = 0, nxt_pend, found;
    logic [15:0]   cnt = '0;
    logic [TW-1:0] mtri = '0;
    int            gnt = 0;
    int            q[$];
    logic [N-1:0]  exp_ready, acc;
    bit            ack;
    int            run_len = 0;
    apply_reset();
    q = '{0, 1, 2, 3};
    acc = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      tick();
      exp_ready = '0; ack = 0; found = 0;
      nxt_pend = (ph == 3) ? swap_req : (pend | swap_req);
      case (ph)
        0: begin
          if (pend) begin ph = 3; sel = ~sel; cnt = '0; ack = 1; end
          else if (req_valid != '0) begin
            for (int k = 0; k < N; k++)
              if (!found && req_valid[q[k]]) begin gnt = q[k]; found = 1; end
            exp_ready[gnt] = 1'b1; ph = 1;
          end
        end
        1: begin
          mtri = req_tri[gnt*TW +: TW];
          while (q[$] != gnt) q.push_back(q.pop_front());
          vld = 1; ph = 2;
        end
        2: if (rast_done) begin vld = 0; if (cnt != 16'hFFFF) cnt++; ph = 0; end
        default: ph = 0;
      endcase
      pend = nxt_pend;

      tests++; if (req_ready !== exp_ready) begin fails++; $display("FAIL rnd_ready cyc %0d: got %b want %b", cyc, req_ready, exp_ready); end
      tests++; if (tri_valid !== vld) begin fails++; $display("FAIL rnd_valid cyc %0d: got %b want %b", cyc, tri_valid, vld); end
      tests++; if (tri_out !== mtri) begin fails++; $display("FAIL rnd_tri cyc %0d: got %h want %h", cyc, tri_out, mtri); end
      tests++; if (swap_ack !== ack) begin fails++; $display("FAIL rnd_ack cyc %0d: got %b want %b", cyc, swap_ack, ack); end
      tests++; if (frame_sel !== sel || fb_base !== (sel ? 26'h4B000 : 26'h0)) begin
        fails++; $display("FAIL rnd_frame cyc %0d: sel=%b fb=%h want sel %b", cyc, frame_sel, fb_base, sel);
      end
      tests++; if (busy !== (ph != 0)) begin fails++; $display("FAIL rnd_busy cyc %0d: got %b want %b", cyc, busy, ph != 0); end
      tests++; if (tri_count !== cnt) begin fails++; $display("FAIL rnd_count cyc %0d: got %0d want %0d", cyc, tri_count, cnt); end
      tests++; if (err_timeout !== 1'b0) begin fails++; $display("FAIL rnd_err cyc %0d: got %b want 0", cyc, err_timeout); end

      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin req_valid[i] = 1'b0; acc[i] = 1'b0; end
        else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          req_tri[i*TW +: TW] = rand_tri(); req_valid[i] = 1'b1;
        end
        if (req_ready[i]) acc[i] = 1'b1;
      end
      run_len   = tri_valid ? run_len + 1 : 0;
      rast_done = tri_valid ? (run_len >= 12 || $urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
      swap_req  = ($urandom_range(0, 11) == 0);
    end
    req_valid = '0; rast_done = 1'b0; swap_req = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_swap_during_run();
    test_merged_swaps();
    test_reset_mid_run();
    test_timeout();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
